// File: rtl/dwt_pkg.sv
// Shared types and sizing helpers for the DWT column-pairing stage.
// Counter widths are derived here so every file sizes them the same way.
package dwt_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ROW_LEN_DEF  = 128;
  localparam int IMG_ROWS_DEF = 256;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W_DEF  = cnt_w(ROW_LEN_DEF);
  localparam int ROW_W_DEF  = cnt_w(IMG_ROWS_DEF);
  localparam int PROW_W_DEF = cnt_w(IMG_ROWS_DEF / 2);

endpackage

// File: rtl/dwt_line_ram.sv
// One-row line buffer: synchronous write, asynchronous read, no reset.
// Contents are only ever overwritten by the next even row.
module dwt_line_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store one coefficient per write strobe.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dwt_col_pair_buf.sv
// Column-pass pairing: buffers an even row, then emits (upper, lower)
// vertical pairs while the following odd row streams in.
module dwt_col_pair_buf
  import dwt_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ROW_LEN  = ROW_LEN_DEF,
  parameter int IMG_ROWS = IMG_ROWS_DEF,
  localparam int COL_W   = cnt_w(ROW_LEN),
  localparam int ROW_W   = cnt_w(IMG_ROWS),
  localparam int PROW_W  = cnt_w(IMG_ROWS / 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              pair_valid,
  output logic [DATA_W-1:0] p1_out,
  output logic [DATA_W-1:0] p2_out,
  output logic [COL_W-1:0]  pair_col,
  output logic [PROW_W-1:0] pair_row,
  output logic              frame_done,
  output logic              sof_err
);

  state_t             state;
  logic [COL_W-1:0]   col_cnt;
  logic [ROW_W-1:0]   row_cnt;
  logic               col_last;
  logic               row_last;
  logic               wr_en;
  logic [COL_W-1:0]   wr_addr;
  logic [DATA_W-1:0]  rd_data;

  assign col_last = (col_cnt == COL_W'(ROW_LEN - 1));
  assign row_last = (row_cnt == ROW_W'(IMG_ROWS - 1));

  // A start-of-frame coefficient always lands in column 0 of a fill row.
  assign wr_en   = in_valid & (in_sof | (state == FILL));
  assign wr_addr = in_sof ? '0 : col_cnt;

  dwt_line_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (ROW_LEN),
    .AW     (COL_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (in_data),
    .raddr (col_cnt),
    .rdata (rd_data)
  );

  // Raster position tracking, fill/pair sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FILL;
      col_cnt    <= '0;
      row_cnt    <= '0;
      pair_valid <= 1'b0;
      p1_out     <= '0;
      p2_out     <= '0;
      pair_col   <= '0;
      pair_row   <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      pair_valid <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      if (in_valid) begin
        if (in_sof) begin
          sof_err <= (col_cnt != '0) || (row_cnt != '0);
          col_cnt <= COL_W'(1);
          row_cnt <= '0;
          state   <= FILL;
        end else if (state == FILL) begin
          if (col_last) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + ROW_W'(1);
            state   <= PAIR;
          end else begin
            col_cnt <= col_cnt + COL_W'(1);
          end
        end else begin
          pair_valid <= 1'b1;
          p1_out     <= rd_data;
          p2_out     <= in_data;
          pair_col   <= col_cnt;
          pair_row   <= PROW_W'(row_cnt >> 1);
          if (col_last) begin
            col_cnt <= '0;
            state   <= FILL;
            if (row_last) begin
              row_cnt    <= '0;
              frame_done <= 1'b1;
            end else begin
              row_cnt <= row_cnt + ROW_W'(1);
            end
          end else begin
            col_cnt <= col_cnt + COL_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dwt_col_pair_buf.sv
// Self-checking bench for dwt_col_pair_buf (ROW_LEN=4, IMG_ROWS=4).
// Expected outputs come from a flat raster-position frame model.
module tb_dwt_col_pair_buf;

  localparam int RL  = 4;
  localparam int NR  = 4;
  localparam int TOT = RL * NR;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sof;
  logic       pair_valid;
  logic [7:0] p1_out;
  logic [7:0] p2_out;
  logic [1:0] pair_col;
  logic [0:0] pair_row;
  logic       frame_done;
  logic       sof_err;

  dwt_col_pair_buf #(
    .DATA_W   (8),
    .ROW_LEN  (RL),
    .IMG_ROWS (NR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .pair_valid (pair_valid),
    .p1_out     (p1_out),
    .p2_out     (p2_out),
    .pair_col   (pair_col),
    .pair_row   (pair_row),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: position within frame plus the whole frame image.
  int         pos = 0;
  logic [7:0] frame [TOT];
  logic       e_pv = 0;
  logic [7:0] e_p1 = 0;
  logic [7:0] e_p2 = 0;
  logic [1:0] e_col = 0;
  logic [0:0] e_row = 0;
  logic       e_fd = 0;
  logic       e_se = 0;

  task automatic model(input logic r, input logic v,
                       input logic [7:0] d, input logic s);
    int rr;
    int cc;
    e_pv = 0;
    e_fd = 0;
    e_se = 0;
    if (!r) begin
      pos = 0;
      e_p1 = 0;
      e_p2 = 0;
      e_col = 0;
      e_row = 0;
      return;
    end
    if (v) begin
      if (s) begin
        e_se = (pos != 0);
        pos = 0;
      end
      frame[pos] = d;
      rr = pos / RL;
      cc = pos % RL;
      if (rr % 2 == 1) begin
        e_pv = 1;
        e_p1 = frame[pos - RL];
        e_p2 = d;
        e_col = 2'(cc);
        e_row = 1'(rr / 2);
        e_fd = (pos == TOT - 1);
      end
      pos = (pos + 1) % TOT;
    end
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [7:0] d, input logic s);
    rst_n = r;
    in_valid = v;
    in_data = d;
    in_sof = s;
    @(posedge clk);
    #1;
    model(r, v, d, s);
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  function automatic logic [21:0] obs();
    return {pair_valid, p1_out, p2_out, pair_col, pair_row,
            frame_done, sof_err};
  endfunction

  function automatic logic [21:0] expv();
    return {e_pv, e_p1, e_p2, e_col, e_row, e_fd, e_se};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(i == 0 ? 1'b0 : 1'b1, 1'b0, 8'h00, 1'b0);
      checks++;
      if (obs() !== 22'h0) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs(), 22'h0);
      end
    end
  endtask

  task automatic test_basic();
    int np = 0;
    int nfd = 0;
    for (int i = 0; i < TOT; i++) begin
      step(1'b1, 1'b1, 8'(10 * (i + 1)), i == 0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL basic i=%0d got=%h exp=%h", i, obs(), expv());
      end
      np += int'(pair_valid);
      nfd += int'(frame_done);
    end
    checks++;
    if (np !== 8 || nfd !== 1 || p1_out !== 8'd120 || p2_out !== 8'd160) begin
      errors++;
      $display("FAIL basic_sum pairs=%0d fd=%0d last=(%0d,%0d) exp 8 1 (120,160)",
               np, nfd, p1_out, p2_out);
    end
  endtask

  task automatic test_gapped();
    for (int i = 0; i < TOT; i++) begin
      step(1'b1, 1'b1, 8'(10 * (i + 1)), i == 0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL gap_v i=%0d got=%h exp=%h", i, obs(), expv());
      end
      for (int g = 0; g < 2; g++) begin
        step(1'b1, 1'b0, 8'($urandom), 1'($urandom));
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL gap_idle i=%0d g=%0d got=%h exp=%h",
                   i, g, obs(), expv());
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int fd_at [$];
    for (int i = 0; i < 2 * TOT; i++) begin
      step(1'b1, 1'b1, 8'($urandom), i == 0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL b2b i=%0d got=%h exp=%h", i, obs(), expv());
      end
      if (frame_done) fd_at.push_back(i);
    end
    checks++;
    if (fd_at.size() != 2 || fd_at[0] != TOT - 1 || fd_at[1] != 2 * TOT - 1) begin
      errors++;
      $display("FAIL b2b_fd count=%0d exp 2 at 15,31", fd_at.size());
    end
  endtask

  task automatic test_resync();
    logic [7:0] d [TOT];
    int nse = 0;
    logic [7:0] f1 = 0;
    logic [7:0] f2 = 0;
    logic got_first = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 8'($urandom), i == 0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rsync_pre i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    for (int i = 0; i < TOT; i++) begin
      d[i] = (i == 0) ? 8'd7 : 8'($urandom);
      step(1'b1, 1'b1, d[i], i == 0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rsync i=%0d got=%h exp=%h", i, obs(), expv());
      end
      nse += int'(sof_err);
      if (pair_valid && !got_first) begin
        got_first = 1;
        f1 = p1_out;
        f2 = p2_out;
      end
    end
    checks++;
    if (nse !== 1 || f1 !== 8'd7 || f2 !== d[4]) begin
      errors++;
      $display("FAIL rsync_sum sof_err=%0d first=(%0d,%0d) exp 1 (7,%0d)",
               nse, f1, f2, d[4]);
    end
  endtask

  task automatic test_reset_mid();
    int nfd = 0;
    for (int i = 0; i < RL + 2; i++) begin
      step(1'b1, 1'b1, 8'($urandom), i == 0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rmid_pre i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    checks++;
    if (obs() !== 22'h0) begin
      errors++;
      $display("FAIL rmid_zero got=%h exp=%h", obs(), 22'h0);
    end
    for (int i = 0; i < TOT; i++) begin
      step(1'b1, 1'b1, 8'($urandom), 1'b0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rmid i=%0d got=%h exp=%h", i, obs(), expv());
      end
      if (frame_done && i != TOT - 1) nfd++;
    end
    checks++;
    if (nfd !== 0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL rmid_fd early=%0d last=%0d exp 0 1", nfd, frame_done);
    end
  endtask

  task automatic test_max();
    for (int i = 0; i < 2 * TOT; i++) begin
      step(1'b1, 1'b1, (i < TOT) ? 8'd255 : 8'd0, 1'b0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL max i=%0d got=%h exp=%h", i, obs(), expv());
      end
      if (i == TOT - 1) begin
        checks++;
        if (p1_out !== 8'd255 || p2_out !== 8'd255) begin
          errors++;
          $display("FAIL max_ff got=(%0d,%0d) exp (255,255)", p1_out, p2_out);
        end
      end
    end
    checks++;
    if (p1_out !== 8'd0 || p2_out !== 8'd0) begin
      errors++;
      $display("FAIL max_00 got=(%0d,%0d) exp (0,0)", p1_out, p2_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'b1, $urandom_range(0, 9) < 7, 8'($urandom),
           $urandom_range(0, 39) == 0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rand i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_sof = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    test_max();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
